// File: rtl/ddr_bridge_burst_master.sv
// ddr_bridge_burst_master
//   Avalon-MM pipelined master driving the s1 (slave) port of the DDR
//   clock-crossing bridge, running entirely on slave_clk. A command either
//   issues a run of pipelined reads or writes an incrementing fill pattern.
//   Returned read data leaves as a valid-only stream with one cycle of latency.
//   A pending-read counter keeps the number of outstanding reads at or below
//   MAX_PENDING so the bridge's downstream FIFO is never over-committed.
//
// Ports
//   slave_clk, slave_reset_n        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready             command handshake (ready only in IDLE)
//   cmd_write/address/length/fill   command payload
//   av_*                            Avalon-MM master towards the bridge
//   rd_data/rd_eop/rd_valid         registered read-return stream
//   busy, done                      status: not-IDLE, completion pulse
//   stray_rdv                       sticky: readdatavalid with nothing pending
module ddr_bridge_burst_master #(
  parameter int ADDR_W      = 24,
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 16,
  parameter int MAX_PENDING = 8
) (
  input  logic              slave_clk,
  input  logic              slave_reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [LEN_W-1:0]  cmd_length,
  input  logic [DATA_W-1:0] cmd_fill_data,
  output logic [ADDR_W-1:0] av_address,
  output logic [ADDR_W-1:0] av_nativeaddress,
  output logic [3:0]        av_byteenable,
  output logic              av_read,
  output logic              av_write,
  output logic [DATA_W-1:0] av_writedata,
  input  logic              av_waitrequest,
  input  logic [DATA_W-1:0] av_readdata,
  input  logic              av_readdatavalid,
  input  logic              av_endofpacket,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_eop,
  output logic              rd_valid,
  output logic              busy,
  output logic              done,
  output logic              stray_rdv
);

  localparam int PEND_W = $clog2(MAX_PENDING + 1);
  localparam logic [PEND_W-1:0] PEND_MAX = PEND_W'(MAX_PENDING);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DRAIN} state_t;

  state_t              state_q;
  logic [LEN_W-1:0]    remaining_q;
  logic [PEND_W-1:0]   pend_q;
  logic [PEND_W-1:0]   pend_d;
  // av_address_q / av_writedata_q double as the address and fill-data
  // pointers: they always hold the word currently (or next) presented.
  logic [ADDR_W-1:0]   av_address_q;
  logic [DATA_W-1:0]   av_writedata_q;
  logic                av_read_q;
  logic                av_write_q;
  logic                rd_valid_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                rd_eop_q;
  logic                done_q;
  logic                stray_q;

  logic                xfer_rd;
  logic                xfer_wr;
  logic                ret_ok;
  logic                last_word;
  logic                rd_room;

  always_comb begin
    xfer_rd   = av_read_q & ~av_waitrequest;
    xfer_wr   = av_write_q & ~av_waitrequest;
    // A return with nothing pending is flagged as stray and never decrements.
    ret_ok    = av_readdatavalid & (pend_q != '0);
    last_word = (remaining_q == LEN_W'(1));
    pend_d    = pend_q;
    if (xfer_rd && !ret_ok) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (!xfer_rd && ret_ok) begin
      pend_d = pend_q - PEND_W'(1);
    end
    // Presenting a read next cycle is allowed only if it still fits once
    // this cycle's completions and returns have been accounted for.
    rd_room   = (pend_d < PEND_MAX);
  end

  always_ff @(posedge slave_clk or negedge slave_reset_n) begin
    if (!slave_reset_n) begin
      state_q        <= IDLE;
      remaining_q    <= '0;
      pend_q         <= '0;
      av_address_q   <= '0;
      av_writedata_q <= '0;
      av_read_q      <= 1'b0;
      av_write_q     <= 1'b0;
      rd_valid_q     <= 1'b0;
      rd_data_q      <= '0;
      rd_eop_q       <= 1'b0;
      done_q         <= 1'b0;
      stray_q        <= 1'b0;
    end else begin
      done_q     <= 1'b0;
      pend_q     <= pend_d;
      rd_valid_q <= av_readdatavalid;
      rd_data_q  <= av_readdata;
      rd_eop_q   <= av_endofpacket;
      if (av_readdatavalid && (pend_q == '0)) begin
        stray_q <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            remaining_q    <= cmd_length;
            av_address_q   <= cmd_address;
            av_writedata_q <= cmd_fill_data;
            if (cmd_length == '0) begin
              done_q <= 1'b1;
            end else if (cmd_write) begin
              state_q    <= WRITE;
              av_write_q <= 1'b1;
            end else begin
              state_q   <= READ;
              av_read_q <= rd_room;
            end
          end
        end

        WRITE: begin
          if (xfer_wr) begin
            av_address_q   <= av_address_q + ADDR_W'(1);
            av_writedata_q <= av_writedata_q + DATA_W'(1);
            remaining_q    <= remaining_q - LEN_W'(1);
            if (last_word) begin
              av_write_q <= 1'b0;
              done_q     <= 1'b1;
              state_q    <= IDLE;
            end
          end
        end

        READ: begin
          if (xfer_rd) begin
            av_address_q <= av_address_q + ADDR_W'(1);
            remaining_q  <= remaining_q - LEN_W'(1);
            if (last_word) begin
              av_read_q <= 1'b0;
              state_q   <= DRAIN;
            end else begin
              av_read_q <= rd_room;
            end
          end else if (!av_read_q) begin
            av_read_q <= rd_room;
          end
        end

        DRAIN: begin
          if ((pend_q == '0) && !av_readdatavalid) begin
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign cmd_ready        = (state_q == IDLE);
  assign busy             = (state_q != IDLE);
  assign done             = done_q;
  assign stray_rdv        = stray_q;
  assign av_address       = av_address_q;
  assign av_nativeaddress = av_address_q;
  assign av_byteenable    = 4'hF;
  assign av_read          = av_read_q;
  assign av_write         = av_write_q;
  assign av_writedata     = av_writedata_q;
  assign rd_valid         = rd_valid_q;
  assign rd_data          = rd_data_q;
  assign rd_eop           = rd_eop_q;

endmodule

// File: tb/tb_ddr_bridge_burst_master.sv
// tb_ddr_bridge_burst_master
//   Directed bench for ddr_bridge_burst_master. A slave model on the falling
//   edge drives waitrequest, returns read data after a programmable latency
//   and logs every completed transfer; the main sequence issues commands and
//   compares the logs with hand-computed values.
`timescale 1ns/1ps
module tb_ddr_bridge_burst_master;
  localparam int ADDR_W = 24;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;
  localparam int MAXP   = 8;

  logic              slave_clk = 1'b0;
  logic              slave_reset_n = 1'b0;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [LEN_W-1:0]  cmd_length;
  logic [DATA_W-1:0] cmd_fill_data;
  logic [ADDR_W-1:0] av_address, av_nativeaddress;
  logic [3:0]        av_byteenable;
  logic              av_read, av_write, av_waitrequest;
  logic [DATA_W-1:0] av_writedata, av_readdata;
  logic              av_readdatavalid, av_endofpacket;
  logic [DATA_W-1:0] rd_data;
  logic              rd_eop, rd_valid, busy, done, stray_rdv;

  always #5 slave_clk = ~slave_clk;

  ddr_bridge_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W), .MAX_PENDING(MAXP)
  ) dut (
    .slave_clk(slave_clk), .slave_reset_n(slave_reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_address(cmd_address), .cmd_length(cmd_length), .cmd_fill_data(cmd_fill_data),
    .av_address(av_address), .av_nativeaddress(av_nativeaddress),
    .av_byteenable(av_byteenable), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_waitrequest(av_waitrequest),
    .av_readdata(av_readdata), .av_readdatavalid(av_readdatavalid),
    .av_endofpacket(av_endofpacket), .rd_data(rd_data), .rd_eop(rd_eop),
    .rd_valid(rd_valid), .busy(busy), .done(done), .stray_rdv(stray_rdv)
  );

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  int cyc = 0;
  always @(posedge slave_clk) cyc <= cyc + 1;

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
    logic              eop;
  } ret_t;

  ret_t              ret_q[$];
  ret_t              r_tmp;
  logic [ADDR_W-1:0] wr_addr_log[$];
  logic [DATA_W-1:0] wr_data_log[$];
  int                wr_cyc_log[$];
  logic [ADDR_W-1:0] rd_addr_log[$];
  int                lat = 12;
  int                done_cnt, done_cyc, rv_cnt, last_rv_cyc, bus_cnt, max_out;
  logic              done_ready;
  logic [DATA_W-1:0] last_rv_data;
  bit                busy_seen;
  int                stall_left = 0;
  logic [ADDR_W-1:0] stall_addr;
  logic [DATA_W-1:0] stall_data;
  bit                stall_active;
  int                hold_bad;
  bit                inject = 0;
  logic [DATA_W-1:0] inject_data;
  bit                arm_first = 0;
  int                reads_at_first, rd_issue;
  logic              prev_rdv, prev_eop;
  logic [DATA_W-1:0] prev_data;

  // Slave model: samples DUT outputs and drives slave inputs on the falling edge.
  initial begin
    av_waitrequest   = 1'b0;
    av_readdatavalid = 1'b0;
    av_readdata      = '0;
    av_endofpacket   = 1'b0;
    prev_rdv = 1'b0; prev_eop = 1'b0; prev_data = '0;
    forever begin
      @(negedge slave_clk);
      if (!slave_reset_n) begin
        av_waitrequest   = 1'b0;
        av_readdatavalid = 1'b0;
        prev_rdv         = 1'b0;
        stall_active     = 1'b0;
      end else begin
        if (prev_rdv || rd_valid) begin
          check_eq("rd_valid", {63'd0, rd_valid}, {63'd0, prev_rdv});
          check_eq("rd_data", {32'd0, rd_data}, {32'd0, prev_data});
          check_eq("rd_eop", {63'd0, rd_eop}, {63'd0, prev_eop});
        end
        if (rd_valid) begin rv_cnt++; last_rv_cyc = cyc; last_rv_data = rd_data; end
        if (done) begin done_cnt++; done_cyc = cyc; done_ready = cmd_ready; end
        if (busy) busy_seen = 1;
        if (av_read || av_write) bus_cnt++;
        if (ret_q.size() + int'(av_read) > max_out) max_out = ret_q.size() + int'(av_read);

        if (stall_left > 0 && (stall_active || (av_write && av_address == stall_addr))) begin
          if (!(av_write && av_address == stall_addr && av_writedata == stall_data)) hold_bad++;
          stall_active   = 1'b1;
          stall_left--;
          av_waitrequest = 1'b1;
        end else begin
          stall_active   = 1'b0;
          av_waitrequest = 1'b0;
        end

        if (av_write && !av_waitrequest) begin
          wr_addr_log.push_back(av_address);
          wr_data_log.push_back(av_writedata);
          wr_cyc_log.push_back(cyc);
        end
        if (av_read && !av_waitrequest) begin
          rd_addr_log.push_back(av_address);
          rd_issue++;
          r_tmp.due  = cyc + lat;
          r_tmp.data = {8'hD0, av_address};
          r_tmp.eop  = (av_address[1:0] == 2'b11);
          ret_q.push_back(r_tmp);
        end

        av_readdatavalid = 1'b0;
        av_readdata      = '0;
        av_endofpacket   = 1'b0;
        if (inject) begin
          av_readdatavalid = 1'b1;
          av_readdata      = inject_data;
          av_endofpacket   = 1'b1;
          inject           = 0;
        end else if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
          r_tmp = ret_q.pop_front();
          av_readdatavalid = 1'b1;
          av_readdata      = r_tmp.data;
          av_endofpacket   = r_tmp.eop;
        end
        if (av_readdatavalid && arm_first) begin
          reads_at_first = rd_issue;
          arm_first      = 0;
        end
        prev_rdv  = av_readdatavalid;
        prev_data = av_readdata;
        prev_eop  = av_endofpacket;
      end
    end
  end

  task automatic step();
    @(negedge slave_clk);
    #1;
  endtask

  task automatic clear_logs();
    wr_addr_log.delete(); wr_data_log.delete(); wr_cyc_log.delete(); rd_addr_log.delete();
    rv_cnt = 0; done_cnt = 0; bus_cnt = 0; busy_seen = 0; max_out = 0;
    hold_bad = 0; rd_issue = 0; reads_at_first = -1;
  endtask

  task automatic issue(input logic wr, input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len,
                       input logic [DATA_W-1:0] fill, output int acc);
    check_eq("cmd_ready_pre", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_address = a; cmd_length = len; cmd_fill_data = fill;
    acc = cyc;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int start;
    bit got;
    start = done_cnt;
    got   = 0;
    for (int i = 0; i < budget && !got; i++) begin
      step();
      got = (done_cnt > start);
    end
    check_eq(tag, {63'd0, got}, 64'd1);
  endtask

  int acc;
  logic [ADDR_W-1:0] exp4[4];

  initial begin
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_address = '0; cmd_length = '0; cmd_fill_data = '0;
    clear_logs();
    repeat (3) step();
    check_eq("rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("rst_byteenable", {60'd0, av_byteenable}, 64'hF);
    check_eq("rst_busy", {63'd0, busy}, 64'd0);
    check_eq("rst_done", {63'd0, done}, 64'd0);
    check_eq("rst_av_rw", {62'd0, av_read, av_write}, 64'd0);
    check_eq("rst_av_addr", {40'd0, av_address}, 64'd0);
    check_eq("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
    check_eq("rst_stray", {63'd0, stray_rdv}, 64'd0);
    slave_reset_n = 1'b1;
    step();

    // 1: four-word fill write, no stalls
    clear_logs();
    issue(1'b1, 24'h000100, 16'd4, 32'hA000_0000, acc);
    wait_done(20, "t1_done_seen");
    check_eq("t1_wr_count", wr_addr_log.size(), 64'd4);
    for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
      check_eq("t1_wr_addr", wr_addr_log[i], 64'h100 + i);
      check_eq("t1_wr_data", wr_data_log[i], 64'hA000_0000 + i);
      check_eq("t1_wr_cyc", wr_cyc_log[i], acc + 1 + i);
    end
    check_eq("t1_done_cyc", done_cyc, acc + 5);
    check_eq("t1_ready_at_done", {63'd0, done_ready}, 64'd1);
    check_eq("t1_done_count", done_cnt, 64'd1);

    // 2: 20 reads, 12-cycle return latency, throttled at 8 outstanding
    clear_logs();
    lat = 12;
    arm_first = 1;
    issue(1'b0, 24'h000200, 16'd20, 32'd0, acc);
    wait_done(200, "t2_done_seen");
    check_eq("t2_rd_count", rd_addr_log.size(), 64'd20);
    for (int i = 0; i < 20 && i < rd_addr_log.size(); i++)
      check_eq("t2_rd_addr", rd_addr_log[i], 64'h200 + i);
    check_eq("t2_reads_before_ret", reads_at_first, 64'd8);
    check_eq("t2_max_outstanding", max_out, 64'd8);
    check_eq("t2_rv_count", rv_cnt, 64'd20);
    check_eq("t2_done_after_last", done_cyc, last_rv_cyc + 1);
    check_eq("t2_done_count", done_cnt, 64'd1);

    // 3: waitrequest held 3 cycles on the second of three writes
    clear_logs();
    stall_addr = 24'h000301;
    stall_data = 32'h0000_0012;
    stall_left = 3;
    issue(1'b1, 24'h000300, 16'd3, 32'h0000_0011, acc);
    wait_done(30, "t3_done_seen");
    check_eq("t3_wr_count", wr_addr_log.size(), 64'd3);
    for (int i = 0; i < 3 && i < wr_addr_log.size(); i++) begin
      check_eq("t3_wr_addr", wr_addr_log[i], 64'h300 + i);
      check_eq("t3_wr_data", wr_data_log[i], 64'h11 + i);
    end
    if (wr_cyc_log.size() > 1) check_eq("t3_second_wr_cyc", wr_cyc_log[1], acc + 5);
    check_eq("t3_hold_violations", hold_bad, 64'd0);
    check_eq("t3_stall_used", stall_left, 64'd0);

    // 4: read address wrap
    clear_logs();
    lat = 3;
    exp4[0] = 24'hFFFFFE; exp4[1] = 24'hFFFFFF; exp4[2] = 24'h000000; exp4[3] = 24'h000001;
    issue(1'b0, 24'hFFFFFE, 16'd4, 32'd0, acc);
    wait_done(50, "t4_done_seen");
    check_eq("t4_rd_count", rd_addr_log.size(), 64'd4);
    for (int i = 0; i < 4 && i < rd_addr_log.size(); i++)
      check_eq("t4_rd_addr", rd_addr_log[i], exp4[i]);
    check_eq("t4_rv_count", rv_cnt, 64'd4);

    // 5: zero-length command
    clear_logs();
    issue(1'b0, 24'h000500, 16'd0, 32'd0, acc);
    repeat (3) step();
    check_eq("t5_done_count", done_cnt, 64'd1);
    check_eq("t5_done_cyc", done_cyc, acc + 1);
    check_eq("t5_bus_cycles", bus_cnt, 64'd0);
    check_eq("t5_busy_seen", {63'd0, busy_seen}, 64'd0);

    // 6a: stray return in IDLE
    clear_logs();
    inject_data = 32'h5A5A_0001;
    inject = 1;
    repeat (3) step();
    check_eq("t6_stray_set", {63'd0, stray_rdv}, 64'd1);
    check_eq("t6_stray_fwd_count", rv_cnt, 64'd1);
    check_eq("t6_stray_fwd_data", last_rv_data, 64'h5A5A_0001);

    // 6b: flag stays set across a command; write wraps address and data
    clear_logs();
    issue(1'b1, 24'hFFFFFF, 16'd2, 32'hFFFF_FFFF, acc);
    wait_done(20, "t6_wr_done_seen");
    check_eq("t6_wr_count", wr_addr_log.size(), 64'd2);
    if (wr_addr_log.size() == 2) begin
      check_eq("t6_wr_addr0", wr_addr_log[0], 64'hFFFFFF);
      check_eq("t6_wr_addr1", wr_addr_log[1], 64'h000000);
      check_eq("t6_wr_data0", wr_data_log[0], 64'hFFFF_FFFF);
      check_eq("t6_wr_data1", wr_data_log[1], 64'h0000_0000);
    end
    check_eq("t6_stray_sticky", {63'd0, stray_rdv}, 64'd1);

    // 6c: reset while draining five outstanding reads
    clear_logs();
    lat = 40;
    issue(1'b0, 24'h000600, 16'd5, 32'd0, acc);
    repeat (8) step();
    check_eq("t6_drain_busy", {63'd0, busy}, 64'd1);
    check_eq("t6_drain_reads", rd_issue, 64'd5);
    check_eq("t6_drain_av_read", {63'd0, av_read}, 64'd0);
    slave_reset_n = 1'b0;
    ret_q.delete();
    #1;
    check_eq("t6_rst_cmd_ready", {63'd0, cmd_ready}, 64'd1);
    check_eq("t6_rst_busy", {63'd0, busy}, 64'd0);
    check_eq("t6_rst_stray", {63'd0, stray_rdv}, 64'd0);
    check_eq("t6_rst_done", {63'd0, done}, 64'd0);
    repeat (2) step();
    slave_reset_n = 1'b1;
    step();
    check_eq("t6_no_done_on_reset", done_cnt, 64'd0);

    // 6d: a full window of reads issues after reset, so pending was cleared
    clear_logs();
    lat = 12;
    arm_first = 1;
    issue(1'b0, 24'h000700, 16'd8, 32'd0, acc);
    wait_done(100, "t6_post_rst_done_seen");
    check_eq("t6_post_rst_window", reads_at_first, 64'd8);
    check_eq("t6_post_rst_rv_count", rv_cnt, 64'd8);
    check_eq("t6_post_rst_no_stray", {63'd0, stray_rdv}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
